// File: rtl/arith_pkg.sv
// Shared types and defaults for the serial arithmetic blocks.
package arith_pkg;

   localparam int ARITH_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin with borrow-out; purely combinational.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial a - b - bin, LSB first, one bit per clk; result valid WIDTH edges after accept.
// Single operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module serial_subtractor_nbit
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               brw_q, brw_d;
   logic               bout_q, bout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               fs_d;
   logic               fs_bo;
   logic               last_bit;
   logic [WIDTH-1:0]   res_shift;

   full_subtractor u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (brw_q),
      .d    (fs_d),
      .bout (fs_bo)
   );

   assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
   assign res_shift = {fs_d, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d = res_shift;
            brw_d = fs_bo;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            // Counter stops at WIDTH-1 so it never wraps for power-of-two widths.
            if (last_bit) begin
               diff_d  = res_shift;
               bout_d  = fs_bo;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   // in_ready is gated by rst_n so it reads 0 throughout reset.
   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule
